// File: rtl/shift_chain_pkg.sv
// Shared types and width helpers for the shift-chain sequencer.
package shift_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int tick_w(input int w, input int d);
        return $clog2(w + d + 1);
    endfunction

    function automatic int div_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/shift_chain_ctrl_ce_tick_gen.sv
// Divided clock-enable generator: one tick every DIV cycles while run.
module ce_tick_gen
    import shift_chain_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CW = div_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run & (cnt == LAST);

endmodule

// File: rtl/shift_chain_ctrl.sv
// Serializes a word through an external DEPTH-stage CE flip-flop chain
// and recaptures the chain output as a parallel word.
module shift_chain_ctrl
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             chain_si,
    output logic             chain_clken,
    input  logic             chain_so,
    output logic             busy
);

    localparam int TW = tick_w(WIDTH, DEPTH);
    localparam logic [TW-1:0] FIRST_RX = TW'(DEPTH);
    localparam logic [TW-1:0] LAST_TICK = TW'(WIDTH + DEPTH - 1);

    generate
        if (WIDTH < 1 || DEPTH < 1 || DIV < 1) begin : g_bad_param
            $error("shift_chain_ctrl: WIDTH, DEPTH and DIV must be >= 1");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] rx_reg;
    logic [TW-1:0]    tick_cnt;
    logic             run;
    logic             tick;

    assign run = (state == SHIFT);

    ce_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .tick  (tick)
    );

    assign chain_clken = tick;
    assign chain_si    = tx_reg[0];
    assign out_data    = rx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_reg    <= '0;
            rx_reg    <= '0;
            tick_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        tx_reg   <= in_data;
                        rx_reg   <= '0;
                        tick_cnt <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        tx_reg   <= tx_reg >> 1;
                        tick_cnt <= tick_cnt + TW'(1);
                        // first DEPTH ticks only flush stale chain data
                        if (tick_cnt >= FIRST_RX) begin
                            rx_reg <= WIDTH'({chain_so, rx_reg} >> 1);
                        end
                        if (tick_cnt == LAST_TICK) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Directed bench: two controllers (DIV=1, DIV=4) each driving a
// behavioral 3-stage CE flip-flop chain.
module tb_shift_chain_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] a_in_data = '0, a_out_data;
    logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
    logic a_si, a_clken, a_so, a_busy;

    logic [7:0] b_in_data = '0, b_out_data;
    logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
    logic b_si, b_clken, b_so, b_busy;

    // chains start with stale contents and have no reset
    logic [2:0] cha = 3'b101;
    logic [2:0] chb = 3'b011;
    always @(posedge clk) if (a_clken) cha <= {cha[1:0], a_si};
    always @(posedge clk) if (b_clken) chb <= {chb[1:0], b_si};
    assign a_so = cha[2];
    assign b_so = chb[2];

    shift_chain_ctrl #(.WIDTH(8), .DEPTH(3), .DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready),
        .chain_si(a_si), .chain_clken(a_clken), .chain_so(a_so),
        .busy(a_busy)
    );

    shift_chain_ctrl #(.WIDTH(8), .DEPTH(3), .DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .chain_si(b_si), .chain_clken(b_clken), .chain_so(b_so),
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] d);
        int n = 0;
        while (a_in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("send_a_ready", {31'd0, a_in_ready}, 32'd1);
        a_in_data = d;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic wait_a(output int edges, output int pulses);
        edges = 0;
        pulses = 0;
        while (a_out_valid !== 1'b1 && edges < 200) begin
            pulses += (a_clken === 1'b1) ? 1 : 0;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    int e, p, viol;
    logic [7:0] stream [4];

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        stream[0] = 8'h00; stream[1] = 8'hFF;
        stream[2] = 8'h5A; stream[3] = 8'hC3;

        // reset asserted mid-cycle
        #12 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_clken", {31'd0, a_clken}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_out_data", {24'd0, a_out_data}, 32'h00);
        chk("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // single word, DIV=1
        send_a(8'hA5);
        chk("a5_busy", {31'd0, a_busy}, 32'd1);
        chk("a5_in_ready", {31'd0, a_in_ready}, 32'd0);
        wait_a(e, p);
        chk("a5_edges", e, 32'd11);
        chk("a5_pulses", p, 32'd11);
        chk("a5_data", {24'd0, a_out_data}, 32'hA5);
        chk("a5_clken_off", {31'd0, a_clken}, 32'd0);
        @(posedge clk); #1;
        chk("a5_drop", {31'd0, a_out_valid}, 32'd0);
        chk("a5_idle", {31'd0, a_in_ready}, 32'd1);

        // DIV=4
        b_in_data = 8'h81;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        e = 0; p = 0; viol = 0;
        while (b_out_valid !== 1'b1 && e < 300) begin
            if (b_clken !== ((e % 4) == 3)) viol++;
            p += (b_clken === 1'b1) ? 1 : 0;
            @(posedge clk); #1;
            e++;
        end
        chk("div4_edges", e, 32'd44);
        chk("div4_pulses", p, 32'd11);
        chk("div4_pattern", viol, 32'd0);
        chk("div4_data", {24'd0, b_out_data}, 32'h81);
        @(posedge clk); #1;
        chk("div4_drop", {31'd0, b_out_valid}, 32'd0);

        // backpressure with competing input held during SHIFT/DONE
        a_out_ready = 1'b0;
        send_a(8'hA5);
        a_in_data = 8'hFF;
        a_in_valid = 1'b1;
        wait_a(e, p);
        chk("bp_edges", e, 32'd11);
        chk("bp_data", {24'd0, a_out_data}, 32'hA5);
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (a_out_data !== 8'hA5 || a_out_valid !== 1'b1 ||
                a_in_ready !== 1'b0) viol++;
        end
        chk("bp_hold", viol, 32'd0);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, a_out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk("bp_ff_taken", {31'd0, a_busy}, 32'd1);
        wait_a(e, p);
        chk("bp_ff_edges", e, 32'd11);
        chk("bp_ff_data", {24'd0, a_out_data}, 32'hFF);
        @(posedge clk); #1;

        // reset in the middle of a transfer
        send_a(8'hE7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_clken", {31'd0, a_clken}, 32'd0);
        chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, a_out_valid}, 32'd0);
        #1 rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_out_valid !== 1'b0) viol++;
        end
        chk("mid_rst_no_out", viol, 32'd0);
        send_a(8'h3C);
        wait_a(e, p);
        chk("stale_edges", e, 32'd11);
        chk("stale_data", {24'd0, a_out_data}, 32'h3C);
        @(posedge clk); #1;

        // back-to-back stream
        for (int i = 0; i < 4; i++) begin
            send_a(stream[i]);
            wait_a(e, p);
            chk("b2b_pulses", p, 32'd11);
            chk("b2b_data", {24'd0, a_out_data}, {24'd0, stream[i]});
        end
        @(posedge clk); #1;
        chk("b2b_end_idle", {31'd0, a_in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
